mult_scheduler: RTL and testbench

- Round-robin scheduler that shares one sequential 8x8 shift-add multiplier among NUM_REQ requesters.
- Arbitrates incoming requests, latches the winner's operands and pulses the multiplier start.
- Waits for the multiplier's done, with a timeout watchdog, then returns the tagged product to the requesters.
- Sits between the requester logic and the sequential multiplier instance inside the multiplier top level.

---
 rtl/mult_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_mult_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin front end that shares one sequential multiplier
// among NUM_REQ requesters. It grants one request at a time, launches the
// multiplier, and waits for done (guarded by a timeout watchdog). It then
// returns a tagged product, or an error response if the watchdog expires.
module mult_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned PW     = 2 * WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic                     rsp_valid,
    output logic [IDW-1:0]           rsp_id,
    output logic [PW-1:0]            rsp_product,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [15:0]              ops_count,
    output logic                     mult_start,
    output logic [WIDTH-1:0]         mult_a,
    output logic [WIDTH-1:0]         mult_b,
    input  logic [PW-1:0]            mult_product,
    input  logic                     mult_done
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     ptr_nxt;
    logic [IDW-1:0]     gid;
    logic [IDW-1:0]     gid_nxt;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic [NUM_REQ-1:0] ack_nxt;
    logic               start_nxt;
    logic [WIDTH-1:0]   a_nxt;
    logic [WIDTH-1:0]   b_nxt;
    logic               valid_nxt;
    logic [IDW-1:0]     id_nxt;
    logic [PW-1:0]      prod_nxt;
    logic               err_nxt;
    logic               busy_nxt;
    logic [15:0]        ops_nxt;

    logic               grant_found;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     scan_idx;
    logic [WIDTH-1:0]   op_a [NUM_REQ];
    logic [WIDTH-1:0]   op_b [NUM_REQ];

    // Unpack the flat operand buses into per-requester words.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_a[g] = req_a[g*WIDTH +: WIDTH];
        assign op_b[g] = req_b[g*WIDTH +: WIDTH];
    end

    // Round-robin search: first set request at or after the pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = IDW'((32'(ptr) + k) % NUM_REQ);
            if (!grant_found && req[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    // Next-state and next-output computation for the scheduler FSM.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gid_nxt   = gid;
        cnt_nxt   = cnt;
        ack_nxt   = '0;
        start_nxt = 1'b0;
        a_nxt     = mult_a;
        b_nxt     = mult_b;
        valid_nxt = 1'b0;
        id_nxt    = rsp_id;
        prod_nxt  = rsp_product;
        err_nxt   = rsp_err;
        ops_nxt   = ops_count;

        case (state)
            IDLE: begin
                if (grant_found) begin
                    // ack and start are registered so both appear during ISSUE
                    state_nxt = ISSUE;
                    gid_nxt   = grant_id;
                    a_nxt     = op_a[grant_id];
                    b_nxt     = op_b[grant_id];
                    ack_nxt   = NUM_REQ'(1) << grant_id;
                    start_nxt = 1'b1;
                end
            end
            ISSUE: begin
                // mult_done may still be the previous operation's flag; ignore it here
                ptr_nxt   = (32'(gid) == NUM_REQ - 1) ? '0 : gid + IDW'(1);
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt + CW'(1);
                if (mult_done) begin
                    // done beats the watchdog when both land on the same cycle
                    state_nxt = RESP;
                    valid_nxt = 1'b1;
                    id_nxt    = gid;
                    prod_nxt  = mult_product;
                    err_nxt   = 1'b0;
                    ops_nxt   = ops_count + 16'd1;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_nxt = RESP;
                    valid_nxt = 1'b1;
                    id_nxt    = gid;
                    prod_nxt  = '0;
                    err_nxt   = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            gid         <= '0;
            cnt         <= '0;
            req_ack     <= '0;
            mult_start  <= 1'b0;
            mult_a      <= '0;
            mult_b      <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            ops_count   <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            gid         <= gid_nxt;
            cnt         <= cnt_nxt;
            req_ack     <= ack_nxt;
            mult_start  <= start_nxt;
            mult_a      <= a_nxt;
            mult_b      <= b_nxt;
            rsp_valid   <= valid_nxt;
            rsp_id      <= id_nxt;
            rsp_product <= prod_nxt;
            rsp_err     <= err_nxt;
            busy        <= busy_nxt;
            ops_count   <= ops_nxt;
        end
    end

endmodule

// File: tb/tb_mult_scheduler.sv
// Testbench for mult_scheduler: a behavioural multiplier plus a scoreboard
// model that predicts grants, products and error responses.
module tb_mult_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ack;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [2*W-1:0] rsp_product;
    logic           rsp_err;
    logic           busy;
    logic [15:0]    ops_count;
    logic           mult_start;
    logic [W-1:0]   mult_a;
    logic [W-1:0]   mult_b;
    logic [2*W-1:0] model_prod = '0;
    logic           model_done = 1'b0;

    mult_scheduler #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .rsp_err(rsp_err), .busy(busy),
        .ops_count(ops_count), .mult_start(mult_start), .mult_a(mult_a),
        .mult_b(mult_b), .mult_product(model_prod), .mult_done(model_done)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: mode 0 normal (latency lat), 1 done stuck low,
    // 2 stale done high until start, then a single late pulse.
    int           mmode = 0;
    int           lat   = 8;
    int           mcnt  = 0;
    bit           fired = 1'b0;
    logic [W-1:0] ma_l  = '0;
    logic [W-1:0] mb_l  = '0;

    always @(posedge clk) begin
        if (mmode != 2) fired <= 1'b0;
        if (mmode == 1) begin
            model_done <= 1'b0;
            mcnt       <= 0;
        end else if (mult_start) begin
            ma_l       <= mult_a;
            mb_l       <= mult_b;
            model_done <= 1'b0;
            mcnt       <= (mmode == 2) ? 5 : lat;
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end else if (mcnt == 1) begin
            mcnt       <= 0;
            model_done <= 1'b1;
            model_prod <= 16'(ma_l) * 16'(mb_l);
            if (mmode == 2) fired <= 1'b1;
        end else if (mmode == 2) begin
            model_done <= !fired;
            if (!fired) model_prod <= 16'hDEAD;
        end
    end

    // Scoreboard state
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           mptr     = 0;
    int           mops     = 0;
    bit           prev_ack = 1'b0;
    bit           prev_rsp = 1'b0;
    logic [N-1:0] hold_mask;
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];
    int           exp_id [$];
    int           exp_prod [$];
    int           exp_err [$];
    int           exp_a [$];
    int           exp_b [$];
    int           issue_cyc [$];
    int           grant_log [$];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        opa[i] = a;
        opb[i] = b;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // One clock: advance, sample outputs 1 time unit after the edge, update model.
    task automatic cycle();
        logic [N-1:0] before_req;
        int id;
        int e_id, e_prod, e_err, e_a, e_b, e_cyc;
        before_req = req;
        @(posedge clk);
        #1;
        cyc++;
        if (prev_rsp) check("busy_after_rsp", int'(busy), 0);
        if (mult_start && req_ack == '0) check("start_without_ack", 1, 0);
        if (req_ack != '0) begin
            id = rr_pick(before_req, mptr);
            check("ack_onehot", int'(req_ack), (id < 0) ? 0 : (1 << id));
            check("ack_single_cycle", int'(prev_ack), 0);
            check("start_with_ack", int'(mult_start), 1);
            if (id >= 0) begin
                check("mult_a", int'(mult_a), int'(opa[id]));
                check("mult_b", int'(mult_b), int'(opb[id]));
                exp_id.push_back(id);
                exp_err.push_back((mmode == 1) ? 1 : 0);
                exp_prod.push_back((mmode == 1) ? 0 : int'(opa[id]) * int'(opb[id]));
                exp_a.push_back(int'(opa[id]));
                exp_b.push_back(int'(opb[id]));
                issue_cyc.push_back(cyc);
                grant_log.push_back(id);
                mptr = (id + 1) % N;
                if (!hold_mask[id]) req[id] = 1'b0;
            end
        end
        if (rsp_valid) begin
            if (exp_id.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                e_id   = exp_id.pop_front();
                e_prod = exp_prod.pop_front();
                e_err  = exp_err.pop_front();
                e_a    = exp_a.pop_front();
                e_b    = exp_b.pop_front();
                e_cyc  = issue_cyc.pop_front();
                if (e_err == 0) mops = (mops + 1) % 65536;
                check("rsp_id", int'(rsp_id), e_id);
                check("rsp_product", int'(rsp_product), e_prod);
                check("rsp_err", int'(rsp_err), e_err);
                check("ops_count", int'(ops_count), mops);
                check("mult_a_stable", int'(mult_a), e_a);
                check("mult_b_stable", int'(mult_b), e_b);
                if (e_err == 1) check("timeout_latency", cyc - e_cyc, TO + 1);
            end
        end
        prev_ack = (req_ack != '0);
        prev_rsp = rsp_valid;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        exp_id.delete();
        exp_prod.delete();
        exp_err.delete();
        exp_a.delete();
        exp_b.delete();
        issue_cyc.delete();
        mptr     = 0;
        mops     = 0;
        prev_ack = 1'b0;
        prev_rsp = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_mult_start", int'(mult_start), 0);
        check("rst_req_ack", int'(req_ack), 0);
        check("rst_ops_count", int'(ops_count), 0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((req != '0 || exp_id.size() != 0 || busy) && n < budget) begin
            cycle();
            n++;
        end
        if (req != '0 || exp_id.size() != 0 || busy) check("drain_timeout", n, -1);
    endtask

    int n0;
    int ops_before;
    int idx;

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_a     = '0;
        req_b     = '0;
        hold_mask = '0;
        for (int i = 0; i < N; i++) set_op(i, '0, '0);
        repeat (2) @(posedge clk);
        do_reset();
        check("rst_rsp_id", int'(rsp_id), 0);
        check("rst_rsp_product", int'(rsp_product), 0);
        check("rst_rsp_err", int'(rsp_err), 0);
        check("rst_mult_a", int'(mult_a), 0);
        check("rst_mult_b", int'(mult_b), 0);

        // Single requester 1: 8*5
        lat = 8;
        set_op(1, 8'd8, 8'd5);
        req = 4'b0010;
        drain(200);
        check("single_ops_count", int'(ops_count), 1);
        check("single_product", int'(rsp_product), 40);

        // All requesters at once from a fresh pointer
        do_reset();
        set_op(0, 8'd12, 8'd12);
        set_op(1, 8'd255, 8'd2);
        set_op(2, 8'd15, 8'd3);
        set_op(3, 8'd255, 8'd255);
        grant_log.delete();
        req = 4'b1111;
        drain(400);
        check("all_grants", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            idx = (i < grant_log.size()) ? grant_log[i] : -1;
            check("all_order", idx, i);
        end
        check("all_last_product", int'(rsp_product), 65025);

        // Fairness: after id 2, requesters 1 and 3 -> 3 first
        set_op(2, 8'd3, 8'd4);
        req = 4'b0100;
        drain(200);
        set_op(1, 8'd6, 8'd7);
        set_op(3, 8'd9, 8'd10);
        grant_log.delete();
        req = 4'b1010;
        drain(400);
        check("fair_first", (grant_log.size() > 0) ? grant_log[0] : -1, 3);
        check("fair_second", (grant_log.size() > 1) ? grant_log[1] : -1, 1);

        // Timeout: done stuck low
        mmode = 1;
        ops_before = int'(ops_count);
        set_op(0, 8'd3, 8'd3);
        req = 4'b0001;
        drain(300);
        check("timeout_ops_unchanged", int'(ops_count), ops_before);
        check("timeout_product", int'(rsp_product), 0);
        mmode = 0;

        // Reset during WAIT with req[0] held
        lat       = 20;
        hold_mask = 4'b0001;
        set_op(0, 8'd11, 8'd13);
        set_op(1, 8'd2, 8'd100);
        req = 4'b0001;
        n0  = 0;
        while (!prev_ack && n0 < 50) begin
            cycle();
            n0++;
        end
        check("rst_test_granted", int'(prev_ack), 1);
        repeat (3) cycle();
        req = 4'b0011;
        do_reset();
        hold_mask = '0;
        lat       = 8;
        grant_log.delete();
        drain(400);
        check("rst_regrant_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        check("rst_regrant_second", (grant_log.size() > 1) ? grant_log[1] : -1, 1);
        check("rst_regrant_ops", int'(ops_count), 2);

        // Stale done entering ISSUE, real pulse later
        mmode = 2;
        cycle();
        cycle();
        set_op(2, 8'd7, 8'd9);
        req = 4'b0100;
        drain(200);
        check("stale_product", int'(rsp_product), 63);
        mmode = 0;
        cycle();

        // Randomized traffic
        for (int t = 0; t < 1500; t++) begin
            lat = int'($urandom_range(1, 10));
            if ($urandom_range(0, 9) < 3) begin
                idx = int'($urandom_range(0, N - 1));
                if (!req[idx]) begin
                    set_op(idx, 8'($urandom), 8'($urandom));
                    req[idx] = 1'b1;
                end
            end
            cycle();
        end
        drain(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
